// File: rtl/exec_pkg.sv
// exec_pkg: shared definitions for the execute sequencer.
//   - DW                : datapath width (fixed at 8 to match the ALU)
//   - OP_*              : command op-codes seen on cmd_op_i
//   - ALU_*             : op encodings driven onto the ALU op_i input
//   - state_t           : sequencer FSM state
//   - op_* helpers      : per-op decode (legality, register write, flag write, ALU op)
// Optional feature macro: EXEC_CMP_EN
//   defined   -> op 011 is CMP (ALU SUB, flags updated, no register write)
//   undefined -> op 011 is illegal
package exec_pkg;

  localparam int DW = 8;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_LDI = 3'b010;
  localparam logic [2:0] OP_CMP = 3'b011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OPER = 2'd1,
    ST_EXEC = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic logic op_cmp_enabled();
`ifdef EXEC_CMP_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic op_legal(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_LDI) ||
           ((op == OP_CMP) && op_cmp_enabled());
  endfunction

  function automatic logic op_writes_reg(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_LDI);
  endfunction

  function automatic logic op_writes_flags(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) ||
           ((op == OP_CMP) && op_cmp_enabled());
  endfunction

  // LDI and illegal ops still stage something onto the ALU; their result is
  // never used, so ADD is as good as anything.
  function automatic logic [2:0] op_to_alu(input logic [2:0] op);
    logic [2:0] a;
    a = ALU_ADD;
    if ((op == OP_SUB) || ((op == OP_CMP) && op_cmp_enabled())) a = ALU_SUB;
    return a;
  endfunction

endpackage

// File: rtl/exec_regfile.sv
// exec_regfile: NREG x DW register file.
//   clk, rst_n           : clock, synchronous active-low reset (clears all entries)
//   we, waddr, wdata     : synchronous write port
//   raddr_y / rdata_y    : combinational operand-y read port
//   raddr_x / rdata_x    : combinational operand-x read port
//   raddr_obs / rdata_obs: combinational observation read port
module exec_regfile
  import exec_pkg::*;
#(
  parameter int NREG = 4,
  localparam int RW = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [RW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [RW-1:0] raddr_y,
  output logic [DW-1:0] rdata_y,
  input  logic [RW-1:0] raddr_x,
  output logic [DW-1:0] rdata_x,
  input  logic [RW-1:0] raddr_obs,
  output logic [DW-1:0] rdata_obs
);

  logic [DW-1:0] regs [NREG];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regs <= '{default: '0};
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_y   = regs[raddr_y];
  assign rdata_x   = regs[raddr_x];
  assign rdata_obs = regs[raddr_obs];

endmodule

// File: rtl/exec_seq.sv
// exec_seq: multi-cycle execute sequencer feeding an external 8-bit ALU.
// Owns the register file and the Z/C flag register. One command at a time:
// IDLE -> OPER -> EXEC -> DONE -> IDLE (one command per 4 cycles).
// Optional feature macro: EXEC_CMP_EN (op 011 = CMP; see exec_pkg).
//
// Handshake: a command transfers on a rising edge where cmd_valid_i and
// cmd_ready_o are both high; cmd_ready_o is high only in IDLE and does not
// depend on cmd_valid_i. All cmd_* fields are sampled only at that edge.
//
// Ports:
//   clk_i, rst_ni             : clock, synchronous active-low reset
//   cmd_valid_i / cmd_ready_o : command handshake
//   cmd_op_i, cmd_dst_i, cmd_srcy_i, cmd_srcx_i, cmd_imm_i : command fields
//   alu_y_o, alu_x_o, alu_op_o: registered ALU inputs (held until next OPER)
//   alu_r_i, alu_fz_i, alu_fc_i: ALU result and flags
//   done_o, illegal_o         : one-cycle completion pulse / rejected command
//   flag_z_o, flag_c_o        : registered flags
//   rd_addr_i / rd_data_o     : combinational observation read
//   dbg_state_o               : current FSM state
module exec_seq
  import exec_pkg::*;
#(
  parameter int NREG = 4,
  localparam int RW = $clog2(NREG)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic [2:0]    cmd_op_i,
  input  logic [RW-1:0] cmd_dst_i,
  input  logic [RW-1:0] cmd_srcy_i,
  input  logic [RW-1:0] cmd_srcx_i,
  input  logic [DW-1:0] cmd_imm_i,
  output logic [DW-1:0] alu_y_o,
  output logic [DW-1:0] alu_x_o,
  output logic [2:0]    alu_op_o,
  input  logic [DW-1:0] alu_r_i,
  input  logic          alu_fz_i,
  input  logic          alu_fc_i,
  output logic          done_o,
  output logic          illegal_o,
  output logic          flag_z_o,
  output logic          flag_c_o,
  input  logic [RW-1:0] rd_addr_i,
  output logic [DW-1:0] rd_data_o,
  output state_t        dbg_state_o
);

  state_t        state, state_nxt;
  logic          hs;

  logic [2:0]    op_q;
  logic [RW-1:0] dst_q, srcy_q, srcx_q;
  logic [DW-1:0] imm_q;

  logic [DW-1:0] opnd_y, opnd_x;
  logic          rf_we;
  logic [DW-1:0] rf_wdata;

  assign hs = cmd_valid_i && cmd_ready_o;

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Next state and Moore outputs
  always_comb begin
    state_nxt   = state;
    cmd_ready_o = 1'b0;
    done_o      = 1'b0;
    illegal_o   = 1'b0;
    case (state)
      ST_IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) state_nxt = ST_OPER;
      end
      ST_OPER: state_nxt = ST_EXEC;
      ST_EXEC: state_nxt = ST_DONE;
      ST_DONE: begin
        done_o    = 1'b1;
        illegal_o = !op_legal(op_q);
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign dbg_state_o = state;

  // Command latch
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      op_q   <= '0;
      dst_q  <= '0;
      srcy_q <= '0;
      srcx_q <= '0;
      imm_q  <= '0;
    end else if (hs) begin
      op_q   <= cmd_op_i;
      dst_q  <= cmd_dst_i;
      srcy_q <= cmd_srcy_i;
      srcx_q <= cmd_srcx_i;
      imm_q  <= cmd_imm_i;
    end
  end

  // Operand staging: sources are captured in OPER, so a dst equal to a
  // source still computes with the pre-write value.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      alu_y_o  <= '0;
      alu_x_o  <= '0;
      alu_op_o <= '0;
    end else if (state == ST_OPER) begin
      alu_y_o  <= opnd_y;
      alu_x_o  <= opnd_x;
      alu_op_o <= op_to_alu(op_q);
    end
  end

  // Flags
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      flag_z_o <= 1'b0;
      flag_c_o <= 1'b0;
    end else if ((state == ST_EXEC) && op_writes_flags(op_q)) begin
      flag_z_o <= alu_fz_i;
      flag_c_o <= alu_fc_i;
    end
  end

  assign rf_we    = (state == ST_EXEC) && op_writes_reg(op_q);
  assign rf_wdata = (op_q == OP_LDI) ? imm_q : alu_r_i;

  exec_regfile #(.NREG(NREG)) u_regfile (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .we        (rf_we),
    .waddr     (dst_q),
    .wdata     (rf_wdata),
    .raddr_y   (srcy_q),
    .rdata_y   (opnd_y),
    .raddr_x   (srcx_q),
    .rdata_x   (opnd_x),
    .raddr_obs (rd_addr_i),
    .rdata_obs (rd_data_o)
  );

endmodule

// File: tb/tb_exec_seq.sv
// tb_exec_seq: directed bench for exec_seq with a behavioural 8-bit ALU.
module tb_exec_seq;
  import exec_pkg::*;

  localparam int NREG = 4;
  localparam int RW   = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [2:0]    cmd_op = '0;
  logic [RW-1:0] cmd_dst = '0, cmd_srcy = '0, cmd_srcx = '0;
  logic [DW-1:0] cmd_imm = '0;
  logic [DW-1:0] alu_y, alu_x, alu_r;
  logic [2:0]    alu_op;
  logic          alu_fz, alu_fc;
  logic          done, illegal, flag_z, flag_c;
  logic [RW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_data;
  state_t        dbg_state;

  exec_seq #(.NREG(NREG)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_op_i    (cmd_op),
    .cmd_dst_i   (cmd_dst),
    .cmd_srcy_i  (cmd_srcy),
    .cmd_srcx_i  (cmd_srcx),
    .cmd_imm_i   (cmd_imm),
    .alu_y_o     (alu_y),
    .alu_x_o     (alu_x),
    .alu_op_o    (alu_op),
    .alu_r_i     (alu_r),
    .alu_fz_i    (alu_fz),
    .alu_fc_i    (alu_fc),
    .done_o      (done),
    .illegal_o   (illegal),
    .flag_z_o    (flag_z),
    .flag_c_o    (flag_c),
    .rd_addr_i   (rd_addr),
    .rd_data_o   (rd_data),
    .dbg_state_o (dbg_state)
  );

  // ---------------- ALU model ----------------
  logic [8:0] alu_full;
  always_comb begin
    alu_full = 9'h000;
    case (alu_op)
      3'b000:  alu_full = {1'b0, alu_y} + {1'b0, alu_x};
      3'b001:  alu_full = {1'b0, alu_y} - {1'b0, alu_x};
      default: alu_full = 9'h0A5;
    endcase
  end
  assign alu_r  = alu_full[7:0];
  assign alu_fz = (alu_full[7:0] == 8'h00);
  assign alu_fc = alu_full[8];

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reg(input int idx, input logic [DW-1:0] exp);
    rd_addr = RW'(idx);
    #1;
    check($sformatf("r%0d", idx), 32'(rd_data), 32'(exp));
  endtask

  task automatic check_flags(input string tag, input logic z, input logic c);
    check({tag, "_z"}, 32'(flag_z), 32'(z));
    check({tag, "_c"}, 32'(flag_c), 32'(c));
  endtask

  // ---------------- driver ----------------
  // Issues one command and checks the done/illegal timing. Returns at the
  // falling edge after DONE (state back in IDLE).
  task automatic run_cmd(input string tag, input logic [2:0] op, input int dst,
                         input int sy, input int sx, input logic [DW-1:0] imm,
                         input logic exp_ill, input logic chk_ops,
                         input logic [DW-1:0] exp_y, input logic [DW-1:0] exp_x);
    @(negedge clk);
    cmd_op    = op;
    cmd_dst   = RW'(dst);
    cmd_srcy  = RW'(sy);
    cmd_srcx  = RW'(sx);
    cmd_imm   = imm;
    cmd_valid = 1'b1;
    for (int i = 0; i < 8 && cmd_ready !== 1'b1; i++) @(negedge clk);
    check({tag, "_ready"}, 32'(cmd_ready), 32'd1);
    @(posedge clk);                       // handshake edge E0
    @(negedge clk);                       // OPER
    cmd_valid = 1'b0;
    cmd_op    = 3'($urandom_range(0, 7));
    cmd_dst   = RW'($urandom_range(0, NREG - 1));
    cmd_srcy  = RW'($urandom_range(0, NREG - 1));
    cmd_srcx  = RW'($urandom_range(0, NREG - 1));
    cmd_imm   = DW'($urandom_range(0, 255));
    check({tag, "_done_c1"}, 32'(done), 32'd0);
    @(negedge clk);                       // EXEC
    check({tag, "_done_c2"}, 32'(done), 32'd0);
    if (chk_ops) begin
      check({tag, "_alu_y"}, 32'(alu_y), 32'(exp_y));
      check({tag, "_alu_x"}, 32'(alu_x), 32'(exp_x));
    end
    @(negedge clk);                       // DONE
    check({tag, "_done_c3"}, 32'(done), 32'd1);
    check({tag, "_illegal"}, 32'(illegal), 32'(exp_ill));
    @(negedge clk);                       // IDLE again
    check({tag, "_done_c4"}, 32'(done), 32'd0);
    check({tag, "_ready_after"}, 32'(cmd_ready), 32'd1);
  endtask

  logic exp_z, exp_c;

  // ---------------- directed sequence ----------------
  initial begin
    // Reset
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_alu_y", 32'(alu_y), 32'd0);
    check("rst_alu_x", 32'(alu_x), 32'd0);
    check("rst_alu_op", 32'(alu_op), 32'd0);
    check_flags("rst", 1'b0, 1'b0);
    for (int i = 0; i < NREG; i++) check_reg(i, 8'h00);

    // ADD with carry out and zero result
    run_cmd("ldi_r1", OP_LDI, 1, 0, 0, 8'hFF, 1'b0, 1'b0, 8'h00, 8'h00);
    run_cmd("ldi_r2", OP_LDI, 2, 0, 0, 8'h01, 1'b0, 1'b0, 8'h00, 8'h00);
    check_flags("ldi_flags", 1'b0, 1'b0);
    check_reg(1, 8'hFF);
    run_cmd("add", OP_ADD, 0, 1, 2, 8'h00, 1'b0, 1'b1, 8'hFF, 8'h01);
    check_reg(0, 8'h00);
    check_flags("add", 1'b1, 1'b1);

    // SUB with borrow, then self-subtract
    run_cmd("ldi_r1b", OP_LDI, 1, 0, 0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    check_flags("ldi_keep", 1'b1, 1'b1);
    run_cmd("ldi_r2b", OP_LDI, 2, 0, 0, 8'h01, 1'b0, 1'b0, 8'h00, 8'h00);
    run_cmd("sub", OP_SUB, 3, 1, 2, 8'h00, 1'b0, 1'b1, 8'h00, 8'h01);
    check_reg(3, 8'hFF);
    check_flags("sub", 1'b0, 1'b1);
    run_cmd("sub_self", OP_SUB, 3, 3, 3, 8'h00, 1'b0, 1'b1, 8'hFF, 8'hFF);
    check_reg(3, 8'h00);
    check_flags("sub_self", 1'b1, 1'b0);

    // Op 011 (CMP or illegal)
    run_cmd("ldi_r0", OP_LDI, 0, 0, 0, 8'h3C, 1'b0, 1'b0, 8'h00, 8'h00);
    run_cmd("ldi_r1c", OP_LDI, 1, 0, 0, 8'h05, 1'b0, 1'b0, 8'h00, 8'h00);
    run_cmd("ldi_r2c", OP_LDI, 2, 0, 0, 8'h05, 1'b0, 1'b0, 8'h00, 8'h00);
    run_cmd("add_r3", OP_ADD, 3, 0, 1, 8'h00, 1'b0, 1'b1, 8'h3C, 8'h05);
    check_reg(3, 8'h41);
    check_flags("add_r3", 1'b0, 1'b0);
`ifdef EXEC_CMP_EN
    run_cmd("cmp", OP_CMP, 0, 1, 2, 8'h99, 1'b0, 1'b1, 8'h05, 8'h05);
    exp_z = 1'b1;
    exp_c = 1'b0;
`else
    run_cmd("op011", OP_CMP, 0, 1, 2, 8'h99, 1'b1, 1'b0, 8'h00, 8'h00);
    exp_z = 1'b0;
    exp_c = 1'b0;
`endif
    check_reg(0, 8'h3C);
    check_flags("op011", exp_z, exp_c);

    // Op 110 is always illegal
    run_cmd("op110", 3'b110, 0, 1, 2, 8'h77, 1'b1, 1'b0, 8'h00, 8'h00);
    check_reg(0, 8'h3C);
    check_reg(1, 8'h05);
    check_flags("op110", exp_z, exp_c);

    // Back-to-back with valid held high, reset during EXEC of the second
    @(negedge clk);
    cmd_op = OP_LDI; cmd_dst = 2'd1; cmd_imm = 8'h5A; cmd_valid = 1'b1;
    check("b2b_ready_a", 32'(cmd_ready), 32'd1);
    @(posedge clk);                       // A accepted
    @(negedge clk);
    cmd_op = OP_LDI; cmd_dst = 2'd2; cmd_imm = 8'h66;
    check("b2b_ready_oper", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    check("b2b_a_done_c2", 32'(done), 32'd0);
    @(negedge clk);
    check("b2b_a_done_c3", 32'(done), 32'd1);
    check_reg(1, 8'h5A);
    @(negedge clk);
    check("b2b_ready_idle", 32'(cmd_ready), 32'd1);
    @(posedge clk);                       // B accepted at first IDLE edge
    @(negedge clk);
    cmd_valid = 1'b0;
    check("b2b_b_oper", 32'(cmd_ready), 32'd0);
    @(negedge clk);                       // EXEC of B
    check("b2b_b_exec_done", 32'(done), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("b2b_rst_done", 32'(done), 32'd0);
    check("b2b_rst_ready", 32'(cmd_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("b2b_no_done", 32'(done), 32'd0);
    end
    for (int i = 0; i < NREG; i++) check_reg(i, 8'h00);
    check_flags("b2b_rst", 1'b0, 1'b0);
    check("b2b_alu_y", 32'(alu_y), 32'd0);
    check("b2b_alu_x", 32'(alu_x), 32'd0);
    check("b2b_alu_op", 32'(alu_op), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  // Global time bound
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
